fetch_timing_unit: RTL

- CPU-side initiator of the 4-bit ROM bus and the source of `opr`, `opa` and `cycle` for the decoder/CC block.
- Generates the 8-state machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) and SYNC, and owns the 12-bit program counter.
- Drives PC nibbles during A1–A3, then captures instruction nibbles from the ROM during M1–M2.
- Tracks two-byte instructions (JCN, FIM, JUN, JMS, ISZ) and accepts jump/branch loads from the execute side.

---
 rtl/tb4004_pkg.sv | 35 +++
 rtl/tb4004_cycle_gen.sv | 40 ++++
 rtl/fetch_timing_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004-style CPU front end: machine-cycle
// encodings, opcode nibbles of the two-byte instructions, and the
// two-byte instruction detector used by fetch and decode.
package tb4004_pkg;

    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cycle_e;

    localparam logic [3:0] JCN     = 4'h1;
    localparam logic [3:0] FIM_SRC = 4'h2;
    localparam logic [3:0] JUN     = 4'h4;
    localparam logic [3:0] JMS     = 4'h5;
    localparam logic [3:0] ISZ     = 4'h7;

    // FIM and SRC share the opr nibble; only FIM (opa bit 0 clear) has a
    // second word.
    function automatic logic isTwoByte(input logic [3:0] opr, input logic [3:0] opa);
        logic result;
        case (opr)
            JCN, JUN, JMS, ISZ: result = 1'b1;
            FIM_SRC:            result = ~opa[0];
            default:            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tb4004_cycle_gen.sv
// Free-running 8-state machine-cycle generator (A1..X3) with a registered
// sync flag that is high while the counter sits in X3.
module tb4004_cycle_gen
    import tb4004_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstN_i,
    output logic [2:0] cycle_o,
    output logic       sync_o
);

    cycle_e state_q;
    cycle_e state_d;
    logic   sync_q;
    logic   sync_d;

    // State register: counter and sync flag move together so sync lines up with X3.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            state_q <= CYC_A1;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
        end
    end

    // Next-state logic: step every clock, wrapping X3 back to A1.
    always_comb begin
        state_d = cycle_e'(state_q + 3'd1);
        sync_d  = (state_d == CYC_X3);
    end

    // Output logic: expose the registered state and sync flag.
    always_comb begin
        cycle_o = state_q;
        sync_o  = sync_q;
    end

endmodule

// File: rtl/fetch_timing_unit.sv
// CPU-side ROM bus initiator: owns the program counter, drives PC nibbles
// in A1-A3, captures instruction nibbles in M1-M2, tracks the second word
// of two-byte instructions and takes jump loads at the end of X3.
module fetch_timing_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [3:0]  dataIn,
    input  logic        jumpEn,
    input  logic [11:0] jumpAddr,
    output logic [2:0]  cycle,
    output logic        sync,
    output logic [3:0]  dataOut,
    output logic        dataOutEn,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic [7:0]  immOut,
    output logic        secondWord,
    output logic [11:0] pc
);

    import tb4004_pkg::*;

    logic [11:0] pc_q;
    logic [11:0] pc_d;
    logic [3:0]  opr_q;
    logic [3:0]  opr_d;
    logic [3:0]  opa_q;
    logic [3:0]  opa_d;
    logic [7:0]  imm_q;
    logic [7:0]  imm_d;
    logic        second_q;
    logic        second_d;

    tb4004_cycle_gen u_cycleGen (
        .clk_i   (clk),
        .rstN_i  (rstN),
        .cycle_o (cycle),
        .sync_o  (sync)
    );

    // Fetch state registers; reset discards any pending second word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc_q     <= RESET_PC;
            opr_q    <= 4'h0;
            opa_q    <= 4'h0;
            imm_q    <= 8'h00;
            second_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            opr_q    <= opr_d;
            opa_q    <= opa_d;
            imm_q    <= imm_d;
            second_q <= second_d;
        end
    end

    // Capture, PC increment and second-word / jump decisions keyed on the machine cycle.
    always_comb begin
        pc_d     = pc_q;
        opr_d    = opr_q;
        opa_d    = opa_q;
        imm_d    = imm_q;
        second_d = second_q;
        case (cycle)
            CYC_M1: begin
                if (second_q) imm_d[7:4] = dataIn;
                else          opr_d      = dataIn;
            end
            CYC_M2: begin
                if (second_q) imm_d[3:0] = dataIn;
                else          opa_d      = dataIn;
                pc_d = pc_q + 12'd1;
            end
            CYC_X3: begin
                if (jumpEn) begin
                    pc_d     = jumpAddr;
                    second_d = 1'b0;
                end else if (!second_q && isTwoByte(opr_q, opa_q)) begin
                    second_d = 1'b1;
                end else begin
                    second_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Bus drive: PC nibbles low-to-high during A1-A3, bus released otherwise.
    always_comb begin
        dataOut   = 4'h0;
        dataOutEn = 1'b0;
        case (cycle)
            CYC_A1: begin
                dataOut   = pc_q[3:0];
                dataOutEn = 1'b1;
            end
            CYC_A2: begin
                dataOut   = pc_q[7:4];
                dataOutEn = 1'b1;
            end
            CYC_A3: begin
                dataOut   = pc_q[11:8];
                dataOutEn = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc         = pc_q;
    assign opr        = opr_q;
    assign opa        = opa_q;
    assign immOut     = imm_q;
    assign secondWord = second_q;

endmodule
